// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// Word-addressed read; the slave returns data for im_addr in the same cycle.
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int IM_AW = 6
);
  logic [IM_AW-1:0] im_addr;
  logic [XLEN-1:0]  im_rdata;

  modport master (output im_addr, input  im_rdata);
  modport slave  (input  im_addr, output im_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: PC register, IR with its PC and valid, redirect/flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              IM_AW    = 6,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            ir_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    im,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic            fetch_misalign
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] inst_p1;
  logic [XLEN-1:0] inst_pc_p1;
  logic            vld_p1;
  logic            ir_load;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_p1;

  // Sticky until reset or an aligned redirect; blocks IR loads meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_p1 <= 1'b0;
    end else if (redirect) begin
      trap_p1 <= |redirect_pc[1:0];
    end
  end

  assign ir_load        = ir_write && !trap_p1;
  assign fetch_misalign = trap_p1;
`else
  logic unused_pc_low;

  assign unused_pc_low  = ^redirect_pc[1:0];
  assign ir_load        = ir_write;
  assign fetch_misalign = 1'b0;
`endif

  // ---- stage 0: fetch PC ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else if (redirect) begin
      pc_p0 <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (pc_write) begin
      pc_p0 <= pc_p0 + XLEN'(4);
    end
  end

  // ---- stage 1: instruction register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_p1    <= NOP_INST;
      inst_pc_p1 <= RESET_PC;
      vld_p1     <= 1'b0;
    end else if (redirect) begin
      inst_p1    <= NOP_INST;
      inst_pc_p1 <= pc_p0;
      vld_p1     <= 1'b0;
    end else if (ir_load) begin
      inst_p1    <= im.im_rdata;
      inst_pc_p1 <= pc_p0;
      vld_p1     <= 1'b1;
    end
  end

  assign im.im_addr = pc_p0[IM_AW+1:2];
  assign pc_out     = pc_p0;
  assign inst       = inst_p1;
  assign inst_pc    = inst_pc_p1;
  assign inst_valid = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_unit;
  localparam int          XLEN   = 32;
  localparam int          IM_AW  = 6;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        ir_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out, inst, inst_pc;
  logic        inst_valid, fetch_misalign;
  logic [31:0] mem [64];

  fetch_unit_if #(.XLEN(XLEN), .IM_AW(IM_AW)) im_bus ();
  assign im_bus.im_rdata = mem[im_bus.im_addr];

  fetch_unit #(.XLEN(XLEN), .IM_AW(IM_AW)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ir_write(ir_write),
    .redirect(redirect), .redirect_pc(redirect_pc), .im(im_bus),
    .pc_out(pc_out), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Architectural model state
  logic [31:0] m_pc, m_inst, m_ipc;
  bit          m_vld, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = NOP; m_ipc = RST_PC; m_vld = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    logic [31:0] old_pc;
    logic [31:0] word;
    old_pc = m_pc;
    word   = mem[(old_pc / 4) % 64];
    if (redirect) begin
      m_pc   = redirect_pc & ~32'd3;
      m_inst = NOP;
      m_ipc  = old_pc;
      m_vld  = 0;
      m_mis  = TRAP && (redirect_pc % 4 != 0);
    end else begin
      if (ir_write && !m_mis) begin
        m_inst = word; m_ipc = old_pc; m_vld = 1;
      end
      if (pc_write) m_pc = old_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic drive(input bit pw, input bit iw, input bit rd, input logic [31:0] rpc);
    pc_write = pw; ir_write = iw; redirect = rd; redirect_pc = rpc;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out", pc_out, m_pc);
      chk("im_addr", 32'(im_bus.im_addr), 32'((m_pc / 4) % 64));
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_valid", 32'(inst_valid), 32'(m_vld));
      chk("fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[16] = 32'hABCD_0001;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_misalign", 32'(fetch_misalign), 32'h0);
    chk("rst_im_addr", 32'(im_bus.im_addr), 32'h0);

    // Sequential fetch
    drive(1, 1, 0, 0);
    step();
    chk("seq1_pc", pc_out, 32'h4);
    chk("seq1_inst", inst, 32'h11);
    chk("seq1_ipc", inst_pc, 32'h0);
    chk("seq1_vld", 32'(inst_valid), 32'h1);
    step();
    chk("seq2_pc", pc_out, 32'h8);
    chk("seq2_inst", inst, 32'h22);

    // Stall for two cycles
    drive(0, 0, 0, 0);
    step(); step();
    chk("stall_pc", pc_out, 32'h8);
    chk("stall_im_addr", 32'(im_bus.im_addr), 32'h2);
    chk("stall_inst", inst, 32'h22);
    chk("stall_ipc", inst_pc, 32'h4);
    chk("stall_vld", 32'(inst_valid), 32'h1);
    drive(1, 1, 0, 0);
    step();
    chk("seq3_pc", pc_out, 32'hC);
    chk("seq3_inst", inst, 32'h33);
    chk("seq3_ipc", inst_pc, 32'h8);

    // Redirect flushes IR, then fetch at target
    drive(0, 1, 1, 32'h40);
    step();
    chk("redir_pc", pc_out, 32'h40);
    chk("redir_inst", inst, 32'h13);
    chk("redir_vld", 32'(inst_valid), 32'h0);
    chk("redir_ipc", inst_pc, 32'hC);
    drive(0, 1, 0, 0);
    step();
    chk("tgt_inst", inst, 32'hABCD_0001);
    chk("tgt_ipc", inst_pc, 32'h40);

    // PC wrap at top of address space
    drive(0, 0, 1, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    chk("wrap_addr0", 32'(im_bus.im_addr), 32'd63);
    drive(1, 0, 0, 0);
    step();
    chk("wrap_pc1", pc_out, 32'h0);
    chk("wrap_addr1", 32'(im_bus.im_addr), 32'd0);

    // Misaligned redirect
    drive(0, 0, 1, 32'h42);
    step();
    chk("mis_pc", pc_out, 32'h40);
    chk("mis_flag", 32'(fetch_misalign), 32'(TRAP));
    drive(0, 1, 0, 0);
    step();
    chk("mis_vld", 32'(inst_valid), 32'(!TRAP));
    drive(0, 0, 1, 32'h80);
    step();
    chk("mis_clear", 32'(fetch_misalign), 32'h0);
    chk("mis_clear_pc", pc_out, 32'h80);

    // Asynchronous reset in the middle of a (misaligned) redirect cycle
    drive(1, 1, 1, 32'h42);
    step();
    drive(1, 1, 1, 32'h104);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_inst", inst, 32'h13);
    chk("arst_ipc", inst_pc, 32'h0);
    chk("arst_vld", 32'(inst_valid), 32'h0);
    chk("arst_mis", 32'(fetch_misalign), 32'h0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    step();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rpc = rpc & 32'h0000_00FC;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, rpc);
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 63)] = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
